// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM encoding,
// byte-enable constants and the data width the lane logic is built for.
package mem_access_stage_pkg;

    // Byte-lane logic below assumes exactly two 8-bit lanes.
    localparam int DATA_W = 16;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte enables for an access of the given size at the given byte offset.
    function automatic logic [1:0] lane_be(input logic is_byte, input logic lsb);
        if (!is_byte) begin
            return BE_WORD;
        end
        return lsb ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and data memory
// (slave).
//
// Handshake: the master raises mem_req together with mem_we, mem_addr,
// mem_be and mem_wdata, and holds all of them stable until the slave returns
// a single-cycle mem_ack. For a read, mem_rdata is valid only in the mem_ack
// cycle. The master drops mem_req on the edge that samples mem_ack; mem_ack
// seen while mem_req is low carries no meaning and is ignored.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [14:0]       mem_addr;
    logic [1:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_access_stage_byte_lane_align.sv
// Combinational byte-lane alignment, little-endian (offset 0 = low byte).
// Store side: byte stores replicate the low byte onto both lanes and enable
// only the addressed lane. Load side: byte loads return the addressed lane
// zero-extended; sign extension is left to writeback.
module byte_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic              st_lsb,
    input  logic              st_byte,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] st_wdata,
    output logic [1:0]        st_be,
    input  logic              ld_lsb,
    input  logic              ld_byte,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    // Store replication and byte-enable generation.
    always_comb begin
        st_wdata = st_data;
        st_be    = lane_be(st_byte, st_lsb);
        if (st_byte) begin
            st_wdata = {st_data[7:0], st_data[7:0]};
        end
    end

    // Load lane extraction.
    always_comb begin
        ld_data = ld_rdata;
        if (ld_byte) begin
            ld_data = {8'h00, (ld_lsb ? ld_rdata[15:8] : ld_rdata[7:0])};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns EX/MEM load/store requests into a req/ack
// access on the data-memory bus, aligns byte lanes, and holds the pipeline
// with stall until the access finishes or times out.
// Optional build macro: MEM_MISALIGN_TRAP_EN (trap misaligned word accesses
// instead of issuing them).
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memRead,
    input  logic                     memWrite,
    input  logic                     storeByte,
    input  logic                     loadByte,
    input  logic [15:0]              addr_IN,
    input  logic [DATA_W-1:0]        storeData_IN,
    mem_access_stage_if.master       bus,
    output logic                     stall,
    output logic [DATA_W-1:0]        readData_OUT,
    output logic                     mem_err,
    output state_t                   state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;

    // Per-access attributes captured at issue; EX/MEM is frozen meanwhile,
    // but latching keeps the load path independent of upstream behaviour.
    logic op_load, op_byte, op_lsb;

    logic access_req, is_byte, misalign;
    logic start_acc, fin_ack, fin_timeout, fin_trap;

    logic [DATA_W-1:0] al_wdata, al_rdata;
    logic [1:0]        al_be;

    // A write wins when both strobes are set, so size follows the store flag.
    assign access_req = memRead | memWrite;
    assign is_byte    = memWrite ? storeByte : loadByte;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = access_req & ~is_byte & addr_IN[0];
`else
    assign misalign = 1'b0;
`endif

    assign state_dbg = state;

    byte_lane_align u_align (
        .st_lsb   (addr_IN[0]),
        .st_byte  (is_byte),
        .st_data  (storeData_IN),
        .st_wdata (al_wdata),
        .st_be    (al_be),
        .ld_lsb   (op_lsb),
        .ld_byte  (op_byte),
        .ld_rdata (bus.mem_rdata),
        .ld_data  (al_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, stall and the one-cycle event strobes for the datapath.
    always_comb begin
        state_nx    = state;
        stall       = 1'b0;
        start_acc   = 1'b0;
        fin_ack     = 1'b0;
        fin_timeout = 1'b0;
        fin_trap    = 1'b0;
        case (state)
            IDLE: begin
                if (access_req) begin
                    stall = 1'b1;
                    if (misalign) begin
                        fin_trap = 1'b1;
                        state_nx = DONE;
                    end else begin
                        start_acc = 1'b1;
                        state_nx  = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                // Ack takes priority over a timeout in the same cycle.
                if (bus.mem_ack) begin
                    fin_ack  = 1'b1;
                    state_nx = DONE;
                end else if (cnt == CNT_LAST) begin
                    fin_timeout = 1'b1;
                    state_nx    = DONE;
                end
            end
            DONE: begin
                // One stall-free cycle; the pending request is not reissued.
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Reset releases the pipeline immediately.
        if (rst) begin
            stall = 1'b0;
        end
    end

    // Bus request fields, result register, error pulse and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            readData_OUT  <= '0;
            mem_err       <= 1'b0;
            cnt           <= '0;
            op_load       <= 1'b0;
            op_byte       <= 1'b0;
            op_lsb        <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            if (start_acc) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= memWrite;
                bus.mem_addr  <= addr_IN[15:1];
                bus.mem_be    <= al_be;
                bus.mem_wdata <= al_wdata;
                cnt           <= '0;
                op_load       <= memRead & ~memWrite;
                op_byte       <= loadByte;
                op_lsb        <= addr_IN[0];
            end
            if (state == WAIT && !fin_ack && !fin_timeout) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (fin_ack) begin
                bus.mem_req  <= 1'b0;
                readData_OUT <= op_load ? al_rdata : '0;
            end
            if (fin_timeout) begin
                bus.mem_req  <= 1'b0;
                readData_OUT <= '0;
                mem_err      <= 1'b1;
            end
            if (fin_trap) begin
                readData_OUT <= '0;
                mem_err      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: word/byte loads and stores, the
// both-strobes case, timeout and ack-at-timeout, misaligned word access
// (either build of MEM_MISALIGN_TRAP_EN) and reset during WAIT.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic              clk;
    logic              rst;
    logic              memRead, memWrite, storeByte, loadByte;
    logic [15:0]       addr_IN;
    logic [DATA_W-1:0] storeData_IN;
    logic              stall;
    logic [DATA_W-1:0] readData_OUT;
    logic              mem_err;
    state_t            state_dbg;

    int checks = 0;
    int errors = 0;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT_CYCLES(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .storeByte    (storeByte),
        .loadByte     (loadByte),
        .addr_IN      (addr_IN),
        .storeData_IN (storeData_IN),
        .bus          (bus),
        .stall        (stall),
        .readData_OUT (readData_OUT),
        .mem_err      (mem_err),
        .state_dbg    (state_dbg)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic sb, input logic lb,
                          input logic [15:0] a, input logic [15:0] d);
        memRead      = rd;
        memWrite     = wr;
        storeByte    = sb;
        loadByte     = lb;
        addr_IN      = a;
        storeData_IN = d;
    endtask

    task automatic clr_op();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic ack(input logic [15:0] d);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = d;
    endtask

    task automatic unack();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
    endtask

    initial begin
        rst = 1'b1;
        clr_op();
        unack();
        tick();
        tick();

        // Reset state.
        chk("rst_req", bus.mem_req, 16'h0);
        chk("rst_we", bus.mem_we, 16'h0);
        chk("rst_addr", bus.mem_addr, 16'h0);
        chk("rst_be", bus.mem_be, 16'h0);
        chk("rst_wdata", bus.mem_wdata, 16'h0);
        chk("rst_rdata", readData_OUT, 16'h0);
        chk("rst_err", mem_err, 16'h0);
        chk("rst_state", state_dbg, 16'(IDLE));
        rst = 1'b0;
        tick();
        chk("idle_stall", stall, 16'h0);

        // Word load at 0x0010, ack on the third WAIT cycle.
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        #1;
        chk("wl_stall_c0", stall, 16'h1);
        tick();
        chk("wl_req", bus.mem_req, 16'h1);
        chk("wl_addr", bus.mem_addr, 16'h0008);
        chk("wl_be", bus.mem_be, 16'h3);
        chk("wl_we", bus.mem_we, 16'h0);
        chk("wl_stall_c1", stall, 16'h1);
        tick();
        chk("wl_stall_c2", stall, 16'h1);
        tick();
        chk("wl_stall_c3", stall, 16'h1);
        ack(16'hBEEF);
        tick();
        unack();
        chk("wl_state_done", state_dbg, 16'(DONE));
        chk("wl_stall_done", stall, 16'h0);
        chk("wl_rdata", readData_OUT, 16'hBEEF);
        chk("wl_req_drop", bus.mem_req, 16'h0);
        chk("wl_err", mem_err, 16'h0);
        ack(16'h1111);              // ack in DONE must be ignored
        tick();
        unack();
        clr_op();
        chk("wl_back_idle", state_dbg, 16'(IDLE));
        chk("wl_no_reissue", bus.mem_req, 16'h0);
        chk("wl_hold", readData_OUT, 16'hBEEF);

        // Byte store at 0x0021, data 0x12AB.
        set_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h12AB);
        tick();
        chk("sb_wdata", bus.mem_wdata, 16'hABAB);
        chk("sb_be", bus.mem_be, 16'h2);
        chk("sb_we", bus.mem_we, 16'h1);
        chk("sb_addr", bus.mem_addr, 16'h0010);
        ack(16'hFFFF);
        tick();
        unack();
        clr_op();
        chk("sb_rdata", readData_OUT, 16'h0000);
        tick();

        // Byte store to the low lane.
        set_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h00C5);
        tick();
        chk("sb_lo_wdata", bus.mem_wdata, 16'hC5C5);
        chk("sb_lo_be", bus.mem_be, 16'h1);
        ack(16'h0000);
        tick();
        unack();
        clr_op();
        tick();

        // Byte loads from 0x0021 (high lane) and 0x0020 (low lane).
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000);
        tick();
        ack(16'h7F3C);
        tick();
        unack();
        clr_op();
        chk("lb_hi", readData_OUT, 16'h007F);
        tick();
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000);
        tick();
        ack(16'h7F3C);
        tick();
        unack();
        clr_op();
        chk("lb_lo", readData_OUT, 16'h003C);
        tick();

        // No ack: abandon after 15 WAIT cycles.
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000);
        tick();
        for (int i = 0; i < 14; i++) begin
            chk("to_req_held", bus.mem_req, 16'h1);
            chk("to_no_err", mem_err, 16'h0);
            tick();
        end
        chk("to_req_last", bus.mem_req, 16'h1);
        chk("to_stall_last", stall, 16'h1);
        tick();
        clr_op();
        chk("to_req_drop", bus.mem_req, 16'h0);
        chk("to_err", mem_err, 16'h1);
        chk("to_rdata", readData_OUT, 16'h0000);
        chk("to_state", state_dbg, 16'(DONE));
        tick();
        chk("to_err_pulse", mem_err, 16'h0);
        chk("to_idle", state_dbg, 16'(IDLE));

        // Ack on the last allowed WAIT cycle: ack wins.
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0044, 16'h0000);
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        ack(16'h5A5A);
        tick();
        unack();
        clr_op();
        chk("ta_err", mem_err, 16'h0);
        chk("ta_rdata", readData_OUT, 16'h5A5A);
        tick();

        // Both strobes: treated as a word store, result zero.
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 16'h0060, 16'h9999);
        tick();
        chk("rw_we", bus.mem_we, 16'h1);
        chk("rw_wdata", bus.mem_wdata, 16'h9999);
        chk("rw_be", bus.mem_be, 16'h3);
        ack(16'hFFFF);
        tick();
        unack();
        clr_op();
        chk("rw_rdata", readData_OUT, 16'h0000);
        tick();

        // Preload a nonzero result, then a misaligned word load at 0x0031.
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000);
        tick();
        ack(16'hC0DE);
        tick();
        unack();
        clr_op();
        chk("pre_rdata", readData_OUT, 16'hC0DE);
        tick();
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0031, 16'h0000);
        #1;
        chk("mis_stall_c0", stall, 16'h1);
`ifdef MEM_MISALIGN_TRAP_EN
        tick();
        clr_op();
        chk("mis_state", state_dbg, 16'(DONE));
        chk("mis_no_req", bus.mem_req, 16'h0);
        chk("mis_err", mem_err, 16'h1);
        chk("mis_rdata", readData_OUT, 16'h0000);
        chk("mis_stall_done", stall, 16'h0);
        tick();
        chk("mis_err_pulse", mem_err, 16'h0);
`else
        tick();
        chk("mis_req", bus.mem_req, 16'h1);
        chk("mis_addr", bus.mem_addr, 16'h0018);
        chk("mis_be", bus.mem_be, 16'h3);
        ack(16'h1234);
        tick();
        unack();
        clr_op();
        chk("mis_err", mem_err, 16'h0);
        chk("mis_rdata", readData_OUT, 16'h1234);
        tick();
`endif

        // Reset asserted on the second WAIT cycle.
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h0000);
        tick();
        tick();
        chk("ra_req_pre", bus.mem_req, 16'h1);
        rst = 1'b1;
        #1;
        chk("ra_req", bus.mem_req, 16'h0);
        chk("ra_stall", stall, 16'h0);
        chk("ra_addr", bus.mem_addr, 16'h0000);
        chk("ra_state", state_dbg, 16'(IDLE));
        chk("ra_rdata", readData_OUT, 16'h0000);
        chk("ra_err", mem_err, 16'h0);
        clr_op();
        tick();
        rst = 1'b0;
        ack(16'hDEAD);
        tick();
        unack();
        chk("late_ack_req", bus.mem_req, 16'h0);
        chk("late_ack_state", state_dbg, 16'(IDLE));
        chk("late_ack_rdata", readData_OUT, 16'h0000);
        chk("late_ack_err", mem_err, 16'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
